// File: rtl/pc_branch_table.sv
// Program counter with a run-time programmable branch-target table.
// Entries are relative offsets or absolute targets; the block also sequences IDLE/RUN/HALT.
module pc_branch_table #(
  parameter int unsigned     PC_W     = 10,
  parameter int unsigned     OFF_W    = 8,
  parameter int unsigned     DEPTH    = 32,
  parameter int unsigned     PTR_W    = $clog2(DEPTH),
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             br_en,
  input  logic             br_take,
  input  logic [PTR_W-1:0] br_ptr,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [OFF_W-1:0] wr_data,
  input  logic             wr_abs,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             halted,
  output logic             bad_ptr
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             bad_q, bad_d;
  logic             tbl_abs_q  [DEPTH];
  logic [OFF_W-1:0] tbl_data_q [DEPTH];

  logic             wr_in_range, br_in_range, wr_ok;
  logic             advance, take;
  logic             sel_abs;
  logic [OFF_W-1:0] sel_data;

  assign wr_in_range = 32'(wr_ptr) < DEPTH;
  assign br_in_range = 32'(br_ptr) < DEPTH;
  assign wr_ok       = wr_en && wr_in_range;
  assign advance     = (state_q == StRun) && !halt_req;
  assign take        = advance && br_en && br_take;

  // Table read with write-first bypass for a same-cycle write to the same entry.
  always_comb begin
    sel_abs  = 1'b0;
    sel_data = OFF_W'(1);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (br_ptr == PTR_W'(i)) begin
        sel_abs  = tbl_abs_q[i];
        sel_data = tbl_data_q[i];
      end
    end
    if (wr_ok && (wr_ptr == br_ptr)) begin
      sel_abs  = wr_abs;
      sel_data = wr_data;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      if (take && br_in_range) begin
        pc_d = sel_abs ? PC_W'(sel_data) : pc_q + PC_W'($signed(sel_data));
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  assign bad_d = bad_q | (wr_en & ~wr_in_range) | (take & ~br_in_range);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (halt_req) state_d = StHalt;
      StHalt:  if (start && !halt_req) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      bad_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_abs_q[i]  <= 1'b0;
        tbl_data_q[i] <= OFF_W'(1);
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_ok && (wr_ptr == PTR_W'(i))) begin
          tbl_abs_q[i]  <= wr_abs;
          tbl_data_q[i] <= wr_data;
        end
      end
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == StRun);
  assign halted  = (state_q == StHalt);
  assign bad_ptr = bad_q;

endmodule

// File: doc/pc_branch_table.md
# pc_branch_table

Programmable branch-target table fused with the program counter. The successor to the fixed combinational PC lookup table. Targets are loaded at run time through a write port instead of being hard-coded. Each entry is tagged relative or absolute, and the block owns the PC register and its run/halt sequencing. It sits between the decoder (which supplies the table pointer and branch condition) and instruction fetch (which consumes `pc`).

## Interface
Parameters:
- `PC_W`, 10: program counter width.
- `OFF_W`, 8: entry payload width (signed offset or unsigned absolute target).
- `DEPTH`, 32: number of table entries, need not be a power of 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse; leaves IDLE/HALT and enters RUN.
- `halt_req` in 1: level; stops the PC at the next edge while in RUN.
- `br_en` in 1: current instruction is a jump/branch using the table.
- `br_take` in 1: branch condition true (tie high for unconditional jump).
- `br_ptr` in PTR_W: table index for this branch.
- `wr_en` in 1: table write strobe.
- `wr_ptr` in PTR_W: write index.
- `wr_data` in OFF_W: entry payload.
- `wr_abs` in 1: 1 = absolute target, 0 = relative offset.
- `pc` out PC_W: current program counter (registered).
- `running` out 1: state == RUN.
- `halted` out 1: state == HALT.
- `bad_ptr` out 1: sticky; set when `br_ptr` or `wr_ptr` is used with a value ≥ DEPTH.

## Operation
- States:
  - IDLE (after reset), RUN, HALT.
  - IDLE -> RUN on `start`.
  - RUN -> HALT on `halt_req`; `halt_req` has priority over `start` in the same cycle.
  - HALT -> RUN on `start` with `halt_req` low.
  - `reset` returns to IDLE from any state.
- Table:
  - DEPTH entries of {abs, data}.
  - Reset initialises every entry to {abs=0, data=+1}, so an unprogrammed branch falls through.
  - Writes are accepted in every state.
- Next PC, evaluated only in RUN with `halt_req` low:
  - `br_en && br_take`, relative entry: pc + sign-extended data, modulo 2^PC_W.
  - `br_en && br_take`, absolute entry: data zero-extended to PC_W, or truncated to its low PC_W bits if OFF_W > PC_W.
  - Otherwise: pc + 1, modulo 2^PC_W (wraps from all-ones to 0).
- A relative offset of 0 holds the PC (spin loop). This is legal and not flagged.
- Out-of-range pointer (≥ DEPTH):
  - A branch uses fall-through pc + 1.
  - A write is dropped.
  - Either case sets `bad_ptr`.
  - `bad_ptr` clears only on `reset`.
- Same-cycle write and branch to the same index: the branch uses the newly written entry (write-first bypass).
- In IDLE or HALT, `pc` holds. `br_en` and `br_take` are ignored and do not set `bad_ptr`; a write with an out-of-range pointer still sets it.

## Timing
- Reset values:
  - `pc` = RESET_PC.
  - `running` = 0, `halted` = 0, `bad_ptr` = 0.
  - All table entries = {0, +1}.
- Next-PC computation is combinational from `pc`, the table and the inputs. `pc` updates on the following edge, so branch latency is 1 cycle with no bubble.
- `start` asserted in cycle n gives `running` = 1 in cycle n+1. The first PC advance occurs at the end of cycle n+1.
- `halt_req` asserted in cycle n (RUN): `pc` does not advance at the end of n, and `halted` = 1 in n+1.
- A table write in cycle n is visible to a branch in cycle n (bypass) and in all later cycles.
- `bad_ptr` rises in the cycle after the offending access.
- `reset` asserted mid-RUN has effect at that edge; a branch in the same cycle is discarded.

## Test plan
- Reset then `start`:
  - Stimulus: hold `br_en` = 0 for 5 cycles.
  - Expect: `pc` reads 0,0,1,2,3,4; `running` = 1 from the cycle after `start`.
- Relative and absolute entries:
  - Stimulus: write entry 3 = {0, −12} and entry 4 = {1, 200}; at pc=20 take entry 3, then take entry 4.
  - Expect: `pc` goes 20 -> 8 -> 200.
- Unprogrammed and untaken branches:
  - Stimulus: take entry 7 (never written) at pc=50; at pc=51 set `br_en` = 1, `br_take` = 0 with entry 3.
  - Expect: `pc` goes 50 -> 51 -> 52.
- Bypass and wrap:
  - Stimulus: in the same cycle write entry 5 = {0, +5} and take entry 5 at pc=1022.
  - Expect: `pc` = 3 (wrap, PC_W=10).
- Halt and resume:
  - Stimulus: assert `halt_req` at pc=9 together with a taken branch; later pulse `start`.
  - Expect: `pc` holds at 9 and `halted` = 1; after `start`, `running` = 1 and `pc` resumes 10, 11.
- Bad pointer (DEPTH=24):
  - Stimulus: take `br_ptr` = 30 at pc=40; write `wr_ptr` = 25; then `reset`.
  - Expect: `pc` = 41; `bad_ptr` = 1 and stays 1; no entry is modified; `reset` clears `bad_ptr` and restores `pc` = 0.
